// File: rtl/daq_line_streamer.sv
// Ping-pong line buffer between ADC capture and the spline / peak-search core.
// Whole lines are captured into one of two banks and streamed out in FIFO order.
module daq_line_streamer #(
    parameter int POINT_NUM_X = 240,
    parameter int POINT_NUM_Y = 220,
    parameter int SAMPLE_BIT  = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  capture_en,
    input  logic                  adc_valid,
    input  logic [SAMPLE_BIT-1:0] adc_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [SAMPLE_BIT-1:0] m_data,
    output logic                  m_last,
    output logic                  m_frame_last,
    output logic [15:0]           m_line_idx,
    output logic [15:0]           ovf_cnt,
    output logic                  ovf_flag
);

    localparam int AW = $clog2(POINT_NUM_X);
    localparam logic [AW-1:0] LAST_ADDR = AW'(POINT_NUM_X - 1);
    localparam logic [15:0]   LAST_LINE = 16'(POINT_NUM_Y - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wrState_t;
    typedef enum logic [1:0] {R_IDLE, R_PREFETCH, R_STREAM} rdState_t;

    wrState_t wrState_q, wrState_d;
    rdState_t rdState_q, rdState_d;

    logic [AW-1:0]         wrAddr_q, wrAddr_d;
    logic                  wrBank_q, wrBank_d;
    logic [15:0]           lineIdx_q, lineIdx_d;
    logic [1:0]            bankFree_q, bankFree_d;
    logic [15:0]           bankTag_q [2];
    logic [15:0]           bankTag_d [2];
    logic [1:0]            fifoCnt_q, fifoCnt_d;
    logic                  fifo0_q, fifo0_d, fifo1_q, fifo1_d;
    logic                  rdBank_q, rdBank_d;
    logic [AW-1:0]         rdAddr_q, rdAddr_d;
    logic                  mValid_q, mValid_d;
    logic                  mLast_q, mLast_d;
    logic                  mFrameLast_q, mFrameLast_d;
    logic [15:0]           mLineIdx_q, mLineIdx_d;
    logic [15:0]           ovfCnt_q, ovfCnt_d;
    logic                  ovfFlag_q, ovfFlag_d;
    logic [SAMPLE_BIT-1:0] ramRd_q;
    logic [SAMPLE_BIT-1:0] lineMem [2][POINT_NUM_X];

    logic          wrStart, wrEnd, claimBank, lastBeat;
    logic          memWe, memWrBank, rdEn, push, pop;
    logic [AW-1:0] memWrAddr, rdRamAddr;

    assign wrStart   = (wrState_q == W_IDLE) && adc_valid && capture_en;
    assign wrEnd     = (wrState_q != W_IDLE) && adc_valid && (wrAddr_q == LAST_ADDR);
    assign claimBank = !bankFree_q[0];
    assign lastBeat  = (rdState_q == R_STREAM) && mValid_q && m_ready && mLast_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wrState_q <= W_IDLE;
            rdState_q <= R_IDLE;
        end else begin
            wrState_q <= wrState_d;
            rdState_q <= rdState_d;
        end
    end

    always_comb begin
        wrState_d = wrState_q;
        case (wrState_q)
            W_IDLE:  if (wrStart) wrState_d = (|bankFree_q) ? W_FILL : W_DROP;
            W_FILL,
            W_DROP:  if (wrEnd) wrState_d = W_IDLE;
            default: wrState_d = W_IDLE;
        endcase
    end

    // Back-to-back lines go straight from the final beat into the next prefetch.
    always_comb begin
        rdState_d = rdState_q;
        case (rdState_q)
            R_IDLE:     if (fifoCnt_q != 2'd0) rdState_d = R_PREFETCH;
            R_PREFETCH: rdState_d = R_STREAM;
            R_STREAM:   if (lastBeat) rdState_d = (fifoCnt_q != 2'd0) ? R_PREFETCH : R_IDLE;
            default:    rdState_d = R_IDLE;
        endcase
    end

    always_comb begin
        wrAddr_d     = wrAddr_q;
        wrBank_d     = wrBank_q;
        lineIdx_d    = lineIdx_q;
        bankFree_d   = bankFree_q;
        bankTag_d    = bankTag_q;
        ovfCnt_d     = ovfCnt_q;
        ovfFlag_d    = ovfFlag_q;
        rdBank_d     = rdBank_q;
        rdAddr_d     = rdAddr_q;
        mValid_d     = mValid_q;
        mLast_d      = mLast_q;
        mFrameLast_d = mFrameLast_q;
        mLineIdx_d   = mLineIdx_q;
        fifoCnt_d    = fifoCnt_q;
        fifo0_d      = fifo0_q;
        fifo1_d      = fifo1_q;
        memWe        = 1'b0;
        memWrBank    = wrBank_q;
        memWrAddr    = wrAddr_q;
        rdEn         = 1'b0;
        rdRamAddr    = rdAddr_q;
        push         = 1'b0;
        pop          = 1'b0;

        case (wrState_q)
            W_IDLE: if (wrStart) begin
                wrAddr_d = AW'(1);
                if (|bankFree_q) begin
                    memWe                 = 1'b1;
                    memWrBank             = claimBank;
                    memWrAddr             = '0;
                    wrBank_d              = claimBank;
                    bankFree_d[claimBank] = 1'b0;
                end
            end
            W_FILL, W_DROP: if (adc_valid) begin
                memWe    = (wrState_q == W_FILL);
                wrAddr_d = wrAddr_q + AW'(1);
                if (wrAddr_q == LAST_ADDR) begin
                    wrAddr_d  = '0;
                    lineIdx_d = (lineIdx_q == LAST_LINE) ? 16'd0 : lineIdx_q + 16'd1;
                    if (wrState_q == W_FILL) begin
                        bankTag_d[wrBank_q] = lineIdx_q;
                        push                = 1'b1;
                    end else begin
                        if (ovfCnt_q != 16'hFFFF) ovfCnt_d = ovfCnt_q + 16'd1;
                        ovfFlag_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if ((rdState_q == R_IDLE || lastBeat) && fifoCnt_q != 2'd0) begin
            pop      = 1'b1;
            rdBank_d = fifo0_q;
        end

        // Output registers only advance on a handshake, so a stall freezes them.
        case (rdState_q)
            R_PREFETCH: begin
                rdEn         = 1'b1;
                rdRamAddr    = '0;
                rdAddr_d     = AW'(1);
                mValid_d     = 1'b1;
                mLast_d      = (LAST_ADDR == '0);
                mLineIdx_d   = bankTag_q[rdBank_q];
                mFrameLast_d = (LAST_ADDR == '0) && (bankTag_q[rdBank_q] == LAST_LINE);
            end
            R_STREAM: if (mValid_q && m_ready) begin
                if (mLast_q) begin
                    mValid_d             = 1'b0;
                    mLast_d              = 1'b0;
                    mFrameLast_d         = 1'b0;
                    bankFree_d[rdBank_q] = 1'b1;
                end else begin
                    rdEn         = 1'b1;
                    rdAddr_d     = rdAddr_q + AW'(1);
                    mLast_d      = (rdAddr_q == LAST_ADDR);
                    mFrameLast_d = (rdAddr_q == LAST_ADDR) && (mLineIdx_q == LAST_LINE);
                end
            end
            default: ;
        endcase

        if (pop) begin
            fifo0_d   = fifo1_q;
            fifoCnt_d = fifoCnt_d - 2'd1;
        end
        if (push) begin
            if (fifoCnt_d == 2'd0) fifo0_d = wrBank_q;
            else                   fifo1_d = wrBank_q;
            fifoCnt_d = fifoCnt_d + 2'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wrAddr_q     <= '0;
            wrBank_q     <= 1'b0;
            lineIdx_q    <= '0;
            bankFree_q   <= 2'b11;
            bankTag_q[0] <= '0;
            bankTag_q[1] <= '0;
            fifoCnt_q    <= '0;
            fifo0_q      <= 1'b0;
            fifo1_q      <= 1'b0;
            rdBank_q     <= 1'b0;
            rdAddr_q     <= '0;
            mValid_q     <= 1'b0;
            mLast_q      <= 1'b0;
            mFrameLast_q <= 1'b0;
            mLineIdx_q   <= '0;
            ovfCnt_q     <= '0;
            ovfFlag_q    <= 1'b0;
        end else begin
            wrAddr_q     <= wrAddr_d;
            wrBank_q     <= wrBank_d;
            lineIdx_q    <= lineIdx_d;
            bankFree_q   <= bankFree_d;
            bankTag_q    <= bankTag_d;
            fifoCnt_q    <= fifoCnt_d;
            fifo0_q      <= fifo0_d;
            fifo1_q      <= fifo1_d;
            rdBank_q     <= rdBank_d;
            rdAddr_q     <= rdAddr_d;
            mValid_q     <= mValid_d;
            mLast_q      <= mLast_d;
            mFrameLast_q <= mFrameLast_d;
            mLineIdx_q   <= mLineIdx_d;
            ovfCnt_q     <= ovfCnt_d;
            ovfFlag_q    <= ovfFlag_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (memWe) lineMem[memWrBank][memWrAddr] <= adc_data;
        if (rdEn)  ramRd_q <= lineMem[rdBank_q][rdRamAddr];
    end

    assign m_valid      = mValid_q;
    assign m_data       = mValid_q ? ramRd_q : '0;
    assign m_last       = mLast_q;
    assign m_frame_last = mFrameLast_q;
    assign m_line_idx   = mLineIdx_q;
    assign ovf_cnt      = ovfCnt_q;
    assign ovf_flag     = ovfFlag_q;

endmodule
